// File: rtl/arbitrated_multiplexer_pkg.sv
// Shared definitions for channel arbitration blocks: arbitration mode and select-width helper.
// Pure types and functions; no latency, no flow control.
package arbitrated_multiplexer_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   // Index width for n channels, never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arbitrated_multiplexer_arbiter_grant.sv
// Combinational grant selection (fixed priority or round-robin from ptr), one-hot and encoded.
// Zero latency; grant is all-zero when no channel requests.
module arbiter_grant
   import arbitrated_multiplexer_pkg::*;
#(
   parameter int        CHANNELS = 8,
   parameter arb_mode_e ARB_MODE = ARB_RR,
   localparam int       SEL_W    = sel_width(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   output logic [CHANNELS-1:0] grant_oh,
   output logic [SEL_W-1:0]    grant_idx
);

   int   idx;
   logic found;

   // Scan offsets 0..CHANNELS-1 from the start point; first requester wins.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < CHANNELS; k++) begin
         idx = (ARB_MODE == ARB_RR) ? int'(ptr) + k : k;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         for (int j = 0; j < CHANNELS; j++) begin
            if (!found && (j == idx) && req[j]) begin
               grant_oh[j] = 1'b1;
               grant_idx   = SEL_W'(j);
               found       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/channel_mux.sv
// Parametrised N:1 data multiplexer, channel 0 in the most significant slice of in_bus.
// Purely combinational; no flow control.
module channel_mux
   import arbitrated_multiplexer_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 8,
   localparam int SEL_W   = sel_width(CHANNELS)
) (
   input  logic [WIDTH*CHANNELS-1:0] in_bus,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_dat
);

   always_comb begin
      out_dat = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (int'(sel) == i) out_dat = in_bus[(CHANNELS-1-i)*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/arbitrated_multiplexer.sv
// N-channel arbitrated multiplexer with registered output; accepted data appears 1 cycle later.
// Output stall (out_valid && !out_ready) drops all in_ready; consume+load on one edge gives full rate.
module arbitrated_multiplexer
   import arbitrated_multiplexer_pkg::*;
#(
   parameter int        WIDTH    = 32,
   parameter int        CHANNELS = 8,
   parameter arb_mode_e ARB_MODE = ARB_RR,
   localparam int       SEL_W    = sel_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH*CHANNELS-1:0] in_bus,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [CHANNELS-1:0] grant_oh;
   logic [SEL_W-1:0]    grant_idx;
   logic [WIDTH-1:0]    mux_dat;
   logic                load;

   logic [WIDTH-1:0]    out_data_q,  out_data_d;
   logic [SEL_W-1:0]    out_sel_q,   out_sel_d;
   logic                out_valid_q, out_valid_d;
   logic [SEL_W-1:0]    ptr_q,       ptr_d;

   arbiter_grant #(
      .CHANNELS (CHANNELS),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr_q),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx)
   );

   channel_mux #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS)
   ) u_mux (
      .in_bus  (in_bus),
      .sel     (grant_idx),
      .out_dat (mux_dat)
   );

   assign load     = (|in_valid) && (!out_valid_q || out_ready);
   assign in_ready = (load && rst_n) ? grant_oh : '0;

   always_comb begin
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_data_d  = mux_dat;
         out_sel_d   = grant_idx;
         out_valid_d = 1'b1;
         // Explicit wrap so non-power-of-two channel counts never point past the last channel.
         if (ARB_MODE == ARB_RR)
            ptr_d = (int'(grant_idx) == CHANNELS-1) ? '0 : grant_idx + 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule
